// File: rtl/sram_ctrl.sv
// sram_ctrl: single-outstanding request initiator for a 256K x 16
// asynchronous SRAM. One valid/ready request at a time is turned into
// a sequenced CE/OE/WE/UB/LB pin pattern. Every pin is a flop loaded on
// the same edge as the state transition, so the pins are glitch-free.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid/ready request handshake; ready is high only in IDLE
//   req_write       1 = write, 0 = read
//   req_addr        18-bit word address
//   req_wdata       16-bit write data
//   req_be          byte enables, [1] upper byte, [0] lower byte
//   rsp_valid       one-cycle completion pulse for reads and writes
//   rsp_rdata       masked read data (0 for writes)
//   sram_addr       SRAM address pins
//   sram_data       SRAM bidirectional data bus
//   sram_*_n        SRAM control pins, active-low
module sram_ctrl #(
   parameter int unsigned READ_WAIT  = 2,
   parameter int unsigned WRITE_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [17:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_be,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [17:0] sram_addr,
   inout  wire  [15:0] sram_data,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   localparam int unsigned AW       = 18;
   localparam int unsigned DW       = 16;
   localparam int unsigned MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int unsigned CW       = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WS   = 3'd2,
      S_WP   = 3'd3,
      S_WH   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            accept;
   logic            rd_done;

   // latched request payload
   logic            write_q;
   logic [1:0]      be_q;
   logic [DW-1:0]   wdata_q;
   logic            data_oe;

   // next values of the registered pins and response
   logic            req_ready_d;
   logic            ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
   logic            data_oe_d;
   logic [1:0]      be_d;
   logic            write_d;
   logic [DW-1:0]   wdata_d;
   logic [AW-1:0]   addr_d;
   logic            rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_d;

   assign accept  = (state_q == S_IDLE) && req_valid;
   assign rd_done = (state_q == S_RD) && (cnt_q == '0);

   // State register with wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; counter reloads whenever a new state is entered
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      case (state_q)
         S_IDLE: if (req_valid) state_d = req_write ? S_WS : S_RD;
         S_RD:   if (cnt_q == '0) state_d = S_IDLE;
         S_WS:   state_d = S_WP;
         S_WP:   if (cnt_q == '0) state_d = S_WH;
         S_WH:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
         case (state_d)
            S_RD:    cnt_d = CW'(READ_WAIT - 1);
            S_WP:    cnt_d = CW'(WRITE_WAIT - 1);
            default: cnt_d = '0;
         endcase
      end
   end

   // Output logic: pin values derived from the state being entered
   always_comb begin
      be_d        = accept ? req_be    : be_q;
      write_d     = accept ? req_write : write_q;
      wdata_d     = accept ? req_wdata : wdata_q;
      addr_d      = accept ? req_addr  : sram_addr;
      req_ready_d = (state_d == S_IDLE);
      ce_n_d      = (state_d == S_IDLE);
      oe_n_d      = (state_d != S_RD);
      we_n_d      = (state_d != S_WP);
      ub_n_d      = (state_d == S_IDLE) || !be_d[1];
      lb_n_d      = (state_d == S_IDLE) || !be_d[0];
      data_oe_d   = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
      rsp_valid_d = rd_done || (state_q == S_WH);
      rsp_rdata_d = rsp_rdata;
      if (rd_done) begin
         rsp_rdata_d = sram_data & {{8{be_q[1]}}, {8{be_q[0]}}};
      end else if (state_q == S_WH) begin
         rsp_rdata_d = '0;
      end
   end

   // Registered pins, payload and response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready <= 1'b1;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_ub_n <= 1'b1;
         sram_lb_n <= 1'b1;
         sram_addr <= '0;
         data_oe   <= 1'b0;
         be_q      <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         req_ready <= req_ready_d;
         sram_ce_n <= ce_n_d;
         sram_oe_n <= oe_n_d;
         sram_we_n <= we_n_d;
         sram_ub_n <= ub_n_d;
         sram_lb_n <= lb_n_d;
         sram_addr <= addr_d;
         data_oe   <= data_oe_d;
         be_q      <= be_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
      end
   end

   // Bus is driven only while data_oe is set (WS/WP/WH)
   assign sram_data = data_oe ? wdata_q : {DW{1'bz}};

endmodule
